tmr_regfile_scrub: RTL

// - Triple-redundant 3-port MIPS register file with a background scrubber, the storage-side partner of the voted ALU.
// - Writes go to all three copies; reads return the bitwise 2-of-3 vote. The scrubber walks r1..r31 and rewrites any copy that disagrees with the majority.
// - Drop-in for regfile in the datapath; scrub status goes to the fault-monitor logic.

---
 rtl/mips_ft_pkg.sv | 10 +
 rtl/maj3.sv | 11 +
 rtl/tmr_regfile_scrub.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_ft_pkg.sv
// mips_ft_pkg: shared scrubber state type, register-file geometry and pointer stepping
package mips_ft_pkg;
   typedef enum logic [1:0] {IDLE, SCAN, FIX} scrub_state_t;
   localparam int NUM_COPIES = 3;
   localparam int REG_AW     = 5;
   localparam int REG_LAST   = 31;
   function automatic logic [REG_AW-1:0] next_ptr(input logic [REG_AW-1:0] p);
      return (p == REG_AW'(REG_LAST)) ? REG_AW'(1) : p + REG_AW'(1);
   endfunction
endpackage

// File: rtl/maj3.sv
// maj3: bitwise 2-of-3 majority vote
module maj3 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] y
);
   assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/tmr_regfile_scrub.sv
// tmr_regfile_scrub: triple-redundant MIPS register file with background scrubber; TMR_SCRUB_FAULT_INJECT_EN adds bit-flip injection ports
module tmr_regfile_scrub
   import mips_ft_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we3,
   input  logic [REG_AW-1:0]     ra1,
   input  logic [REG_AW-1:0]     ra2,
   input  logic [REG_AW-1:0]     wa3,
   input  logic [WIDTH-1:0]      wd3,
   output logic [WIDTH-1:0]      rd1,
   output logic [WIDTH-1:0]      rd2,
   input  logic                  scrub_en,
   output logic                  corrected,
   output logic [REG_AW-1:0]     fix_addr,
   output logic [CNT_WIDTH-1:0]  err_count
`ifdef TMR_SCRUB_FAULT_INJECT_EN
   ,
   input  logic                  inj_en,
   input  logic [1:0]            inj_copy,
   input  logic [REG_AW-1:0]     inj_addr,
   input  logic [4:0]            inj_bit
`endif
);
   logic [WIDTH-1:0]     r_mem [NUM_COPIES][2**REG_AW];
   scrub_state_t         r_state;
   logic [REG_AW-1:0]    r_ptr;
   logic                 r_corrected;
   logic [REG_AW-1:0]    r_fix_addr;
   logic [CNT_WIDTH-1:0] r_err_count;
   logic [WIDTH-1:0]     w_rd1_vote;
   logic [WIDTH-1:0]     w_rd2_vote;
   logic [WIDTH-1:0]     w_scrub_vote;
   logic                 w_user_wr;
   logic                 w_ptr_hit;
   logic                 w_mismatch;
   logic                 w_fix_wr;
`ifdef TMR_SCRUB_FAULT_INJECT_EN
   logic                 w_inj;
`endif

   // user writes to r0 are discarded; a write at the scrub pointer pre-empts the scrubber
   assign w_user_wr  = we3 && wa3 != '0;
   assign w_ptr_hit  = we3 && wa3 == r_ptr;
   assign w_mismatch = r_mem[0][r_ptr] != r_mem[1][r_ptr] || r_mem[0][r_ptr] != r_mem[2][r_ptr];
   assign w_fix_wr   = r_state == FIX && !w_ptr_hit;
`ifdef TMR_SCRUB_FAULT_INJECT_EN
   assign w_inj = inj_en && inj_copy != 2'd3 && inj_addr != '0 && !(we3 && wa3 == inj_addr)
                  && !(r_state == FIX && r_ptr == inj_addr);
`endif

   maj3 #(.WIDTH(WIDTH)) u_maj_rd1 (.a(r_mem[0][ra1]), .b(r_mem[1][ra1]), .c(r_mem[2][ra1]), .y(w_rd1_vote));
   maj3 #(.WIDTH(WIDTH)) u_maj_rd2 (.a(r_mem[0][ra2]), .b(r_mem[1][ra2]), .c(r_mem[2][ra2]), .y(w_rd2_vote));
   maj3 #(.WIDTH(WIDTH)) u_maj_scr (.a(r_mem[0][r_ptr]), .b(r_mem[1][r_ptr]), .c(r_mem[2][r_ptr]), .y(w_scrub_vote));

   assign rd1       = ra1 == '0 ? '0 : w_rd1_vote;
   assign rd2       = ra2 == '0 ? '0 : w_rd2_vote;
   assign corrected = r_corrected;
   assign fix_addr  = r_fix_addr;
   assign err_count = r_err_count;

   // storage: scrub repair, then user write last so it wins on any overlap
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_COPIES; c++)
            for (int a = 0; a <= REG_LAST; a++)
               r_mem[c][a] <= '0;
      end else begin
         for (int c = 0; c < NUM_COPIES; c++) begin
            if (w_fix_wr) r_mem[c][r_ptr] <= w_scrub_vote;
            if (w_user_wr) r_mem[c][wa3] <= wd3;
         end
`ifdef TMR_SCRUB_FAULT_INJECT_EN
         if (w_inj) r_mem[inj_copy][inj_addr][inj_bit] <= ~r_mem[inj_copy][inj_addr][inj_bit];
`endif
      end
   end

   // scrubber: walk r1..r31, divert to FIX on disagreement, report repairs the cycle after FIX
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ptr       <= REG_AW'(1);
         r_corrected <= 1'b0;
         r_fix_addr  <= '0;
         r_err_count <= '0;
      end else begin
         r_corrected <= 1'b0;
         case (r_state)
            IDLE: if (scrub_en) r_state <= SCAN;
            SCAN: begin
               if (w_mismatch && !w_ptr_hit) r_state <= FIX;
               else begin
                  r_ptr <= next_ptr(r_ptr);
                  if (!scrub_en) r_state <= IDLE;
               end
            end
            FIX: begin
               r_ptr   <= next_ptr(r_ptr);
               r_state <= scrub_en ? SCAN : IDLE;
               if (!w_ptr_hit) begin
                  r_corrected <= 1'b1;
                  r_fix_addr  <= r_ptr;
                  r_err_count <= r_err_count == '1 ? r_err_count : r_err_count + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
